// File: rtl/store_pkg.sv
// Shared definitions for the store buffer: funct3 store encodings and
// the FIFO entry layout.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } st_entry_t;

endpackage

// File: rtl/store_buffer_unit_if.sv
// Store buffer bus: MEM-stage store request, RAM drain port, load hit probe
// and status. The master side is the surrounding pipeline/RAM, the slave
// side is the store buffer itself.
interface store_buffer_unit_if;

  logic        i_st_valid;
  logic        o_st_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [2:0]  i_funct3;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_ld_addr;
  logic        o_ld_hit;
  logic        o_empty;
  logic        o_misaligned;

  modport master (
    output i_st_valid, i_addr, i_wdata, i_funct3, i_mem_ready, i_ld_addr,
    input  o_st_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_bmask,
           o_ld_hit, o_empty, o_misaligned
  );

  modport slave (
    input  i_st_valid, i_addr, i_wdata, i_funct3, i_mem_ready, i_ld_addr,
    output o_st_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_bmask,
           o_ld_hit, o_empty, o_misaligned
  );

endinterface

// File: rtl/store_lane_align.sv
// Store lane steering: places SB/SH/SW data on byte lanes and builds the
// byte mask. Optional macro STORE_MISALIGN_TRAP_EN enables the misaligned
// flag; without it the flag is constant 0.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic [3:0]  bmask,
  output logic        op_ok,
  output logic        misaligned
);

  logic mis_raw;

  // Decode store size into lane data and byte enables
  always_comb begin
    data    = '0;
    bmask   = '0;
    op_ok   = 1'b0;
    mis_raw = 1'b0;
    case (funct3)
      F3_SB: begin
        data  = {4{wdata[7:0]}};
        bmask = 4'b0001 << addr_lo;
        op_ok = 1'b1;
      end
      F3_SH: begin
        data    = {2{wdata[15:0]}};
        bmask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        op_ok   = 1'b1;
        mis_raw = addr_lo[0];
      end
      F3_SW: begin
        data    = wdata;
        bmask   = '1;
        op_ok   = 1'b1;
        mis_raw = |addr_lo;
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = mis_raw;
`else
  logic unused_mis;
  assign unused_mis = mis_raw;
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/store_buffer_unit.sv
// In-order store buffer: steers MEM-stage stores onto byte lanes, queues
// them in a DEPTH-entry FIFO, drains to data RAM over valid/ready and flags
// loads that hit a pending word. Optional macro STORE_MISALIGN_TRAP_EN
// drops misaligned SH/SW and pulses o_misaligned instead.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  store_buffer_unit_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  st_entry_t      fifo [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;

  logic [31:0]    al_data;
  logic [3:0]     al_bmask;
  logic           al_ok;
  logic           al_mis;
  logic           push_acc;
  logic           queue;
  logic           pop;
  st_entry_t      head;

  store_lane_align u_align (
    .funct3     (bus.i_funct3),
    .addr_lo    (bus.i_addr[1:0]),
    .wdata      (bus.i_wdata),
    .data       (al_data),
    .bmask      (al_bmask),
    .op_ok      (al_ok),
    .misaligned (al_mis)
  );

  assign bus.o_st_ready  = (count != (PW+1)'(DEPTH));
  assign bus.o_mem_valid = (count != '0);
  assign bus.o_empty     = (count == '0);

  assign push_acc = bus.i_st_valid & bus.o_st_ready;
  assign queue    = push_acc & al_ok & ~al_mis;
  assign pop      = bus.o_mem_valid & bus.i_mem_ready;

  // Pointer and occupancy bookkeeping; reset discards all pending entries
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (queue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({queue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents need no reset since outputs are gated by count
  always_ff @(posedge i_clk) begin
    if (i_reset && queue) begin
      fifo[wr_ptr] <= '{waddr: bus.i_addr[31:2], wdata: al_data, bmask: al_bmask};
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  // One-cycle pulse for a consumed misaligned store
  always_ff @(posedge i_clk) begin
    if (!i_reset) bus.o_misaligned <= 1'b0;
    else          bus.o_misaligned <= push_acc & al_mis;
  end
`else
  assign bus.o_misaligned = 1'b0;
`endif

  assign head            = fifo[rd_ptr];
  assign bus.o_mem_addr  = bus.o_mem_valid ? {head.waddr, 2'b00} : '0;
  assign bus.o_mem_wdata = bus.o_mem_valid ? head.wdata : '0;
  assign bus.o_mem_bmask = bus.o_mem_valid ? head.bmask : '0;

  // Slot i is occupied when its distance from rd_ptr is below count
  always_comb begin
    logic [PW-1:0] off;
    bus.o_ld_hit = 1'b0;
    off          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (fifo[i].waddr == bus.i_ld_addr[31:2]))
        bus.o_ld_hit = 1'b1;
    end
  end

  logic unused_ld;
  assign unused_ld = &{1'b0, bus.i_ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer_unit.sv
module tb_store_buffer_unit;
  import store_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_unit_if bus ();

  store_buffer_unit #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ment_t;

  ment_t q[$];
  logic  mis_q = 1'b0;
  int    passed = 0;
  int    failed = 0;
  int    total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected entry built byte by byte from the store-size rules
  function automatic ment_t steer(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    ment_t r;
    int n, start;
    if (f3 == F3_SB)      begin n = 1; start = int'(a[1:0]); end
    else if (f3 == F3_SH) begin n = 2; start = a[1] ? 2 : 0; end
    else                  begin n = 4; start = 0; end
    for (int k = 0; k < 4; k++) begin
      if (f3 == F3_SB)      r.d[8*k +: 8] = d[7:0];
      else if (f3 == F3_SH) r.d[8*k +: 8] = d[8*(k%2) +: 8];
      else                  r.d[8*k +: 8] = d[8*k +: 8];
    end
    r.m  = 4'(((1 << n) - 1) << start);
    r.wa = a[31:2];
    return r;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [2:0] f3);
    return (f3 == F3_SH && a[0]) || (f3 == F3_SW && a[1:0] != 2'b00);
  endfunction

  task automatic check_outputs(input logic [31:0] la);
    bit hit;
    hit = 0;
    foreach (q[i]) if (q[i].wa == la[31:2]) hit = 1;
    chk("st_ready",  {31'b0, bus.o_st_ready},  {31'b0, q.size() != DEPTH});
    chk("mem_valid", {31'b0, bus.o_mem_valid}, {31'b0, q.size() != 0});
    chk("empty",     {31'b0, bus.o_empty},     {31'b0, q.size() == 0});
    chk("mem_addr",  bus.o_mem_addr,  q.size() != 0 ? {q[0].wa, 2'b00} : 32'h0);
    chk("mem_wdata", bus.o_mem_wdata, q.size() != 0 ? q[0].d : 32'h0);
    chk("mem_bmask", {28'b0, bus.o_mem_bmask}, q.size() != 0 ? {28'b0, q[0].m} : 32'h0);
    chk("ld_hit",    {31'b0, bus.o_ld_hit},    {31'b0, hit});
    chk("misaligned",{31'b0, bus.o_misaligned},{31'b0, mis_q});
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance model over the edge
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic mr, input logic [31:0] la,
                      input logic rn);
    bit acc, pp, trap;
    bus.i_st_valid  = v;
    bus.i_addr      = a;
    bus.i_wdata     = d;
    bus.i_funct3    = f3;
    bus.i_mem_ready = mr;
    bus.i_ld_addr   = la;
    rst_n           = rn;
    #1;
    check_outputs(la);
    if (!rn) begin
      q.delete();
      mis_q = 1'b0;
    end else begin
      acc = v && (q.size() != DEPTH);
      pp  = (q.size() != 0) && mr;
`ifdef STORE_MISALIGN_TRAP_EN
      trap = acc && misal(a, f3);
`else
      trap = 0;
`endif
      if (pp) void'(q.pop_front());
      if (acc && f3 <= 3'b010 && !trap) q.push_back(steer(a, d, f3));
      mis_q = trap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic mr, input logic [31:0] la);
    bus.i_st_valid  = 1'b0;
    bus.i_mem_ready = mr;
    bus.i_ld_addr   = la;
    #1;
  endtask

  initial begin
    bus.i_st_valid  = 1'b0;
    bus.i_addr      = '0;
    bus.i_wdata     = '0;
    bus.i_funct3    = '0;
    bus.i_mem_ready = 1'b0;
    bus.i_ld_addr   = '0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state (still in reset)
    step(0, 0, 0, F3_SB, 0, 0, 0);
    chk("rst_empty", {31'b0, bus.o_empty}, 32'h1);

    // 1: SB to byte 3
    step(1, 32'h0000_1003, 32'h0000_00AB, F3_SB, 1, 0, 1);
    idle(0, 0);
    chk("t1_addr",  bus.o_mem_addr, 32'h0000_1000);
    chk("t1_bmask", {28'b0, bus.o_mem_bmask}, 32'h8);
    chk("t1_byte3", {24'b0, bus.o_mem_wdata[31:24]}, 32'hAB);

    // 2: SH upper half, then SW, each popping the previous head
    step(1, 32'h0000_2002, 32'hFFFF_1234, F3_SH, 1, 0, 1);
    idle(0, 0);
    chk("t2_sh_bmask", {28'b0, bus.o_mem_bmask}, 32'hC);
    chk("t2_sh_hi",    {16'b0, bus.o_mem_wdata[31:16]}, 32'h1234);
    step(1, 32'h0000_3000, 32'hDEAD_BEEF, F3_SW, 1, 0, 1);
    idle(0, 0);
    chk("t2_sw_bmask", {28'b0, bus.o_mem_bmask}, 32'hF);
    chk("t2_sw_data",  bus.o_mem_wdata, 32'hDEAD_BEEF);
    step(0, 0, 0, F3_SB, 1, 0, 1);

    // 3: fill with RAM stalled, fifth push refused, then drain in order
    for (int i = 0; i < 4; i++)
      step(1, 32'h100 + 32'(4*i), 32'h1111_0000 + 32'(i), F3_SW, 0, 0, 1);
    idle(0, 0);
    chk("t3_full", {31'b0, bus.o_st_ready}, 32'h0);
    step(1, 32'h200, 32'h5555_5555, F3_SW, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 0);
      chk("t3_order", bus.o_mem_addr, 32'h100 + 32'(4*i));
      step(0, 0, 0, F3_SB, 1, 0, 1);
    end
    idle(0, 0);
    chk("t3_empty", {31'b0, bus.o_empty}, 32'h1);

    // 4: load hit compare on word address
    step(1, 32'h400, 32'hCAFE_F00D, F3_SW, 0, 32'h400, 1);
    idle(0, 32'h402);
    chk("t4_hit", {31'b0, bus.o_ld_hit}, 32'h1);
    idle(0, 32'h404);
    chk("t4_miss", {31'b0, bus.o_ld_hit}, 32'h0);

    // 5: reset with two entries pending, mid-handshake
    step(1, 32'h408, 32'h0000_0077, F3_SB, 0, 0, 1);
    step(0, 0, 0, F3_SB, 1, 0, 0);
    idle(1, 32'h400);
    chk("t5_valid", {31'b0, bus.o_mem_valid}, 32'h0);
    chk("t5_empty", {31'b0, bus.o_empty}, 32'h1);
    repeat (2) step(0, 0, 0, F3_SB, 1, 32'h400, 1);

    // 6: misaligned SH
    step(1, 32'h5001, 32'h0000_ABCD, F3_SH, 0, 0, 1);
    idle(0, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("t6_mis",   {31'b0, bus.o_misaligned}, 32'h1);
    chk("t6_empty", {31'b0, bus.o_empty}, 32'h1);
    step(0, 0, 0, F3_SB, 0, 0, 1);
    chk("t6_mis_clr", {31'b0, bus.o_misaligned}, 32'h0);
`else
    chk("t6_bmask", {28'b0, bus.o_mem_bmask}, 32'h3);
    chk("t6_mis",   {31'b0, bus.o_misaligned}, 32'h0);
    chk("t6_empty", {31'b0, bus.o_empty}, 32'h0);
`endif
    repeat (2) step(0, 0, 0, F3_SB, 1, 0, 1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d, la;
      logic [2:0]  f3;
      a  = {20'h0, 2'b0, 6'($urandom_range(0, 7)), 2'($urandom)} << 0;
      a  = 32'h0000_0800 + {a[29:0], 2'b00} + 32'($urandom_range(0, 3));
      d  = $urandom;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      la = 32'h0000_0800 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 2) != 0), a, d, f3, 1'($urandom_range(0, 2) == 0),
           la, 1'($urandom_range(0, 99) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
